// File: rtl/seg7_capture_decoder_if.sv
// ---------------------------------------------------------------------------
// seg7_capture_decoder_if
// Bundles the 7-segment capture bus with the decoded results that are
// returned from the capture decoder.
//   seg_in      : active-low segments, digit i at [7i+6:7i], order g..a
//   sample_en   : one-cycle strobe to sample seg_in
//   busy        : decoder is accumulating, sample_en is ignored
//   digits_out  : last committed hex digits, digit i at [4i+3:4i]
//   value       : last committed binary value of the decimal digits
//   value_ok    : value agrees with digits_out (all digits 0-9)
//   update      : one-cycle pulse when digits_out/value refresh
//   err         : sticky flag, a stable pattern had an undecodable digit
//   err_mask    : per-digit invalid flags of the last erroneous pattern
// master = display/stimulus side, slave = capture decoder.
// ---------------------------------------------------------------------------
interface seg7_capture_decoder_if #(
   parameter int NUM_DIGITS = 3,
   parameter int VAL_W      = 10
);
   logic [7*NUM_DIGITS-1:0] seg_in;
   logic                    sample_en;
   logic                    busy;
   logic [4*NUM_DIGITS-1:0] digits_out;
   logic [VAL_W-1:0]        value;
   logic                    value_ok;
   logic                    update;
   logic                    err;
   logic [NUM_DIGITS-1:0]   err_mask;

   modport master (
      output seg_in, sample_en,
      input  busy, digits_out, value, value_ok, update, err, err_mask
   );

   modport slave (
      input  seg_in, sample_en,
      output busy, digits_out, value, value_ok, update, err, err_mask
   );
endinterface

// File: rtl/seg7_capture_decoder.sv
// ---------------------------------------------------------------------------
// seg7_capture_decoder
// Receive side of the BPM 7-segment display bus. Samples NUM_DIGITS
// active-low segment patterns, waits until the same pattern has been seen
// STABLE_SAMPLES times in a row, decodes each digit to hex and converts the
// decimal digits to binary with a one-digit-per-cycle multiply-accumulate.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg7_capture_decoder_if.slave (segment input, strobe, results)
// ---------------------------------------------------------------------------
module seg7_capture_decoder #(
   parameter int NUM_DIGITS     = 3,
   parameter int STABLE_SAMPLES = 4,
   parameter int VAL_W          = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seg7_capture_decoder_if.slave  bus
);

   localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_SAMPLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
   localparam logic [IDX_W-1:0] IDX_MSD  = IDX_W'(NUM_DIGITS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [7*NUM_DIGITS-1:0] snap_q, snap_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [VAL_W-1:0]        acc_q, acc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] lat_q, lat_d;
   logic                    nonbcd_q, nonbcd_d;
   logic                    busy_q, busy_d;
   logic [4*NUM_DIGITS-1:0] digits_out_q, digits_out_d;
   logic [VAL_W-1:0]        value_q, value_d;
   logic                    value_ok_q, value_ok_d;
   logic                    update_q, update_d;
   logic                    err_q, err_d;
   logic [NUM_DIGITS-1:0]   err_mask_q, err_mask_d;

   logic [4*NUM_DIGITS-1:0] dec_digits;
   logic [NUM_DIGITS-1:0]   dec_invalid;
   logic [4:0]              dec_entry;
   logic [3:0]              cur_digit;

   // Returns {valid, hex}; only exact matches of the display font decode.
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      logic [4:0] r;
      r = 5'h00;
      case (s)
         7'h40: r = 5'h10;
         7'h79: r = 5'h11;
         7'h24: r = 5'h12;
         7'h30: r = 5'h13;
         7'h19: r = 5'h14;
         7'h12: r = 5'h15;
         7'h02: r = 5'h16;
         7'h78: r = 5'h17;
         7'h00: r = 5'h18;
         7'h10: r = 5'h19;
         7'h08: r = 5'h1A;
         7'h03: r = 5'h1B;
         7'h46: r = 5'h1C;
         7'h21: r = 5'h1D;
         7'h06: r = 5'h1E;
         7'h0E: r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // Decode every digit of the live input; only consumed on a stable event,
   // at which point seg_in equals the stored snapshot.
   always_comb begin
      dec_digits  = '0;
      dec_invalid = '0;
      dec_entry   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dec_entry             = decode_seg(bus.seg_in[7*i +: 7]);
         dec_digits[4*i +: 4]  = dec_entry[3:0];
         dec_invalid[i]        = ~dec_entry[4];
      end
   end

   assign cur_digit = lat_q[4*idx_q +: 4];

   // Sampling/stability tracking in IDLE, then MSD-first accumulation and a
   // single DONE cycle that publishes the result.
   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      lat_d        = lat_q;
      nonbcd_d     = nonbcd_q;
      busy_d       = busy_q;
      digits_out_d = digits_out_q;
      value_d      = value_q;
      value_ok_d   = value_ok_q;
      update_d     = 1'b0;
      err_d        = err_q;
      err_mask_d   = err_mask_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.sample_en) begin
               snap_d = bus.seg_in;
               if (bus.seg_in == snap_q) begin
                  // A saturated counter stays put so a held pattern never
                  // re-commits; only the step onto the limit is an event.
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (cnt_q == CNT_LAST) begin
                     if (|dec_invalid) begin
                        err_d      = 1'b1;
                        err_mask_d = dec_invalid;
                     end else begin
                        state_d  = ST_ACCUM;
                        busy_d   = 1'b1;
                        acc_d    = '0;
                        idx_d    = IDX_MSD;
                        lat_d    = dec_digits;
                        nonbcd_d = 1'b0;
                     end
                  end
               end else begin
                  cnt_d = CNT_W'(1);
               end
            end
         end

         ST_ACCUM: begin
            // acc*10 as shift-add, truncated to VAL_W.
            acc_d = (acc_q << 3) + (acc_q << 1) + VAL_W'(cur_digit);
            if (cur_digit > 4'd9) begin
               nonbcd_d = 1'b1;
            end
            if (idx_q == '0) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end

         ST_DONE: begin
            digits_out_d = lat_q;
            update_d     = 1'b1;
            if (!nonbcd_q) begin
               value_d    = acc_q;
               value_ok_d = 1'b1;
            end else begin
               value_ok_d = 1'b0;
            end
            err_d      = 1'b0;
            err_mask_d = '0;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Snapshot resets to all ones, i.e. a blank display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         snap_q       <= '1;
         cnt_q        <= '0;
         acc_q        <= '0;
         idx_q        <= '0;
         lat_q        <= '0;
         nonbcd_q     <= 1'b0;
         busy_q       <= 1'b0;
         digits_out_q <= '0;
         value_q      <= '0;
         value_ok_q   <= 1'b0;
         update_q     <= 1'b0;
         err_q        <= 1'b0;
         err_mask_q   <= '0;
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         lat_q        <= lat_d;
         nonbcd_q     <= nonbcd_d;
         busy_q       <= busy_d;
         digits_out_q <= digits_out_d;
         value_q      <= value_d;
         value_ok_q   <= value_ok_d;
         update_q     <= update_d;
         err_q        <= err_d;
         err_mask_q   <= err_mask_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.digits_out = digits_out_q;
   assign bus.value      = value_q;
   assign bus.value_ok   = value_ok_q;
   assign bus.update     = update_q;
   assign bus.err        = err_q;
   assign bus.err_mask   = err_mask_q;

endmodule
